// File: rtl/mont_pkg.sv
// Shared types and elaboration helpers for the radix-2^DIGIT Montgomery multiplier.
// Holds the FSM state type, the legal-DIGIT check and the counter-width function.
package mont_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SUB  = 2'd2
    } stateT;

    // Bit d is set when DIGIT=d is a supported radix (1, 2, 4, 8).
    localparam logic [8:0] LEGAL_DIGITS = 9'b1_0001_0110;

    function automatic bit digitLegal(input int d);
        return (d >= 1 && d <= 8) ? LEGAL_DIGITS[d] : 1'b0;
    endfunction

    // Ceiling log2, never below 1 so a counter always has at least one bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/mont_digit_step.sv
// One combinational Montgomery iteration: T = C + a_d*B, q = T*m' mod 2^DIGIT,
// cOut = (T + q*M) >> DIGIT. Ports: cIn/cOut (WIDTH+1), b, m (WIDTH), aDigit, mPrime (DIGIT).
module mont_digit_step #(
    parameter int WIDTH = 1024,
    parameter int DIGIT = 1
) (
    input  logic [WIDTH:0]   cIn,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    input  logic [DIGIT-1:0] aDigit,
    input  logic [DIGIT-1:0] mPrime,
    output logic [WIDTH:0]   cOut
);

    localparam int XW = WIDTH + DIGIT + 2;

    logic [XW-1:0]    bExt;
    logic [XW-1:0]    mExt;
    logic [XW-1:0]    t;
    logic [XW-1:0]    u;
    logic [DIGIT-1:0] q;
    logic             unusedBits;

    assign bExt = XW'(b);
    assign mExt = XW'(m);

    // Shift-add instead of a full multiplier: the digit is only DIGIT bits wide.
    always_comb begin
        t = XW'(cIn);
        for (int i = 0; i < DIGIT; i++) begin
            if (aDigit[i]) t = t + (bExt << i);
        end
    end

    assign q = t[DIGIT-1:0] * mPrime;

    always_comb begin
        u = t;
        for (int i = 0; i < DIGIT; i++) begin
            if (q[i]) u = u + (mExt << i);
        end
    end

    // Low DIGIT bits of u are zero by choice of q; the top bit stays clear since C < 2M.
    assign cOut       = u[WIDTH+DIGIT:DIGIT];
    assign unusedBits = ^{u[XW-1], u[DIGIT-1:0]};

endmodule

// File: rtl/montgomery_rk.sv
// Radix-2^DIGIT Montgomery multiplier: result = A*B*2^-WIDTH mod M, start/done handshake.
// Ports: clk, reset (sync, high), start, in_a/in_b/in_m, in_mprime -> busy, done, result.
// MONT_FINAL_SUB_EN adds a final conditional subtract (result < M, one extra cycle).
module montgomery_rk
    import mont_pkg::*;
#(
    parameter int WIDTH = 1024,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_m,
    input  logic [DIGIT-1:0] in_mprime,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int ITER = WIDTH / DIGIT;
    localparam int CW   = clog2(ITER);

    if (!digitLegal(DIGIT) || (WIDTH % DIGIT) != 0) begin : gBadParam
        $error("montgomery_rk: illegal WIDTH/DIGIT combination");
    end

    stateT            state;
    logic [WIDTH-1:0] aReg;
    logic [WIDTH-1:0] bReg;
    logic [WIDTH-1:0] mReg;
    logic [DIGIT-1:0] mpReg;
    logic [WIDTH:0]   cReg;
    logic [WIDTH:0]   cNext;
    logic [CW-1:0]    counter;

    mont_digit_step #(
        .WIDTH (WIDTH),
        .DIGIT (DIGIT)
    ) uStep (
        .cIn    (cReg),
        .b      (bReg),
        .m      (mReg),
        .aDigit (aReg[DIGIT-1:0]),
        .mPrime (mpReg),
        .cOut   (cNext)
    );

`ifdef MONT_FINAL_SUB_EN
    logic [WIDTH+1:0] diff;

    // Sign bit diff[WIDTH+1] set means C < M, so C is already reduced.
    assign diff = {1'b0, cReg} - {2'b00, mReg};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            cReg    <= '0;
            counter <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        aReg    <= in_a;
                        bReg    <= in_b;
                        mReg    <= in_m;
                        mpReg   <= in_mprime;
                        cReg    <= '0;
                        counter <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    cReg    <= cNext;
                    aReg    <= aReg >> DIGIT;
                    counter <= counter + CW'(1);
                    if (counter == CW'(ITER - 1)) begin
`ifdef MONT_FINAL_SUB_EN
                        state <= SUB;
`else
                        state  <= IDLE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        result <= cNext[WIDTH-1:0];
`endif
                    end
                end
`ifdef MONT_FINAL_SUB_EN
                SUB: begin
                    if (!diff[WIDTH+1]) begin
                        cReg   <= diff[WIDTH:0];
                        result <= diff[WIDTH-1:0];
                    end else begin
                        result <= cReg[WIDTH-1:0];
                    end
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_montgomery_rk.sv
// Directed and random checks of montgomery_rk at WIDTH=8/DIGIT=2 and WIDTH=64/DIGIT=1,4.
// Follows MONT_FINAL_SUB_EN for expected latency and result reduction.
module tb_montgomery_rk;

`ifdef MONT_FINAL_SUB_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic [7:0] m8 = 8'd13;
    logic [1:0] mp8 = 2'd3;
    logic       busy8;
    logic       done8;
    logic [7:0] res8;

    montgomery_rk #(.WIDTH(8), .DIGIT(2)) dut8 (
        .clk(clk), .reset(reset), .start(start8),
        .in_a(a8), .in_b(b8), .in_m(m8), .in_mprime(mp8),
        .busy(busy8), .done(done8), .result(res8)
    );

    logic        startW = 1'b0;
    logic [63:0] aW = '0;
    logic [63:0] bW = '0;
    logic [63:0] mW = 64'd13;
    logic [0:0]  mp1 = 1'b1;
    logic [3:0]  mp4 = 4'd3;
    logic        busy1, done1, busy4, done4;
    logic [63:0] res1, res4;

    montgomery_rk #(.WIDTH(64), .DIGIT(1)) dutW1 (
        .clk(clk), .reset(reset), .start(startW),
        .in_a(aW), .in_b(bW), .in_m(mW), .in_mprime(mp1),
        .busy(busy1), .done(done1), .result(res1)
    );

    montgomery_rk #(.WIDTH(64), .DIGIT(4)) dutW4 (
        .clk(clk), .reset(reset), .start(startW),
        .in_a(aW), .in_b(bW), .in_m(mW), .in_mprime(mp4),
        .busy(busy4), .done(done4), .result(res4)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Without final subtract the block returns a value < 2M congruent to the answer.
    function automatic logic [63:0] norm(input logic [63:0] r, input logic [63:0] m);
`ifdef MONT_FINAL_SUB_EN
        return r;
`else
        return (r < 2 * m) ? r % m : r;
`endif
    endfunction

    // Reference: reduce A*B, then halve mod M WIDTH times (odd M).
    function automatic logic [63:0] montRef(input logic [63:0] a, input logic [63:0] b,
                                            input logic [63:0] m, input int w);
        logic [127:0] p;
        p = ({64'b0, a} * {64'b0, b}) % {64'b0, m};
        for (int i = 0; i < w; i++) begin
            if (p[0]) p = p + {64'b0, m};
            p = p >> 1;
        end
        return p[63:0];
    endfunction

    task automatic run8(input logic [7:0] a, input logic [7:0] b,
                        output int lat, output logic [7:0] res);
        @(negedge clk);
        a8 = a; b8 = b; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        chk("busy_after_start", {63'b0, busy8}, 64'd1);
        lat = -1;
        res = '0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (done8) begin
                lat = n;
                res = res8;
                chk("busy_low_at_done", {63'b0, busy8}, 64'd0);
                break;
            end
        end
        @(posedge clk); #1;
        chk("done_one_cycle", {63'b0, done8}, 64'd0);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp;
    } vec8T;

    vec8T vecs[8];

    initial begin
        int lat, pulses, lat1, lat4;
        logic [7:0] res;
        logic [63:0] r1, r4, expW;

        vecs[0] = '{a: 8'd5,  b: 8'd7,  exp: 8'd1};
        vecs[1] = '{a: 8'd12, b: 8'd12, exp: 8'd3};
        vecs[2] = '{a: 8'd0,  b: 8'd9,  exp: 8'd0};
        vecs[3] = '{a: 8'd9,  b: 8'd0,  exp: 8'd0};
        vecs[4] = '{a: 8'd1,  b: 8'd1,  exp: 8'd3};
        vecs[5] = '{a: 8'd12, b: 8'd1,  exp: 8'd10};
        vecs[6] = '{a: 8'd2,  b: 8'd11, exp: 8'd1};
        vecs[7] = '{a: 8'd7,  b: 8'd5,  exp: 8'd1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset_busy", {63'b0, busy8}, 64'd0);
        chk("reset_done", {63'b0, done8}, 64'd0);
        chk("reset_result", {56'b0, res8}, 64'd0);

        for (int i = 0; i < 8; i++) begin
            run8(vecs[i].a, vecs[i].b, lat, res);
            chk($sformatf("lat8_v%0d", i), 64'(lat), 64'(4 + EXTRA));
            chk($sformatf("res8_v%0d", i), norm({56'b0, res}, 64'd13), {56'b0, vecs[i].exp});
        end

        // Second start and operand change while busy must be ignored.
        @(negedge clk);
        a8 = 8'd5; b8 = 8'd7; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        pulses = 0; lat = -1; res = '0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            start8 = (n == 2);
            if (n == 2) begin a8 = 8'd12; b8 = 8'd12; end
            if (n == 3) a8 = 8'd0;
            @(posedge clk); #1;
            if (done8) begin
                pulses++;
                if (lat < 0) begin lat = n; res = res8; end
            end
        end
        start8 = 1'b0;
        chk("ignore_pulses", 64'(pulses), 64'd1);
        chk("ignore_lat", 64'(lat), 64'(4 + EXTRA));
        chk("ignore_res", norm({56'b0, res}, 64'd13), 64'd1);

        // Reset sampled at edge 3 of a running operation aborts it.
        @(negedge clk);
        a8 = 8'd12; b8 = 8'd12; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_busy", {63'b0, busy8}, 64'd0);
        chk("abort_result", {56'b0, res8}, 64'd0);
        pulses = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (done8) pulses++;
        end
        chk("abort_no_done", 64'(pulses), 64'd0);
        run8(8'd5, 8'd7, lat, res);
        chk("after_abort_lat", 64'(lat), 64'(4 + EXTRA));
        chk("after_abort_res", norm({56'b0, res}, 64'd13), 64'd1);

        // Random 64-bit operands on DIGIT=1 and DIGIT=4 side by side.
        for (int v = 0; v < 8; v++) begin
            logic [63:0] m;
            m = {$urandom, $urandom};
            m[63] = 1'b0;
            m[0] = 1'b1;
            if (m < 64'd3) m = 64'd1000003;
            @(negedge clk);
            mW = m;
            aW = {$urandom, $urandom} % m;
            bW = {$urandom, $urandom} % m;
            for (int x = 0; x < 16; x++) begin
                if (((int'(m[3:0]) * x) & 15) == 15) mp4 = 4'(x);
            end
            expW = montRef(aW, bW, m, 64);
            startW = 1'b1;
            @(posedge clk); #1;
            startW = 1'b0;
            lat1 = -1; lat4 = -1; r1 = '0; r4 = '0;
            for (int n = 1; n <= 100; n++) begin
                @(posedge clk); #1;
                if (done1 && lat1 < 0) begin lat1 = n; r1 = res1; end
                if (done4 && lat4 < 0) begin lat4 = n; r4 = res4; end
                if (lat1 >= 0 && lat4 >= 0) break;
            end
            chk($sformatf("latW1_v%0d", v), 64'(lat1), 64'(64 + EXTRA));
            chk($sformatf("latW4_v%0d", v), 64'(lat4), 64'(16 + EXTRA));
            chk($sformatf("resW1_v%0d", v), norm(r1, m), expW);
            chk($sformatf("resW4_v%0d", v), norm(r4, m), expW);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
